// File: rtl/seg7_pkg.sv
// Shared types and segment encodings for the MM.SS 7-segment display stage.
package seg7_pkg;

  localparam int unsigned VAL_W      = 6;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [VAL_W-1:0] MAX_TIME_VAL = 6'd59;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
  localparam logic [9:0][SEG_W-1:0] SEG_DIGIT = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef logic [1:0] digit_idx_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [VAL_W-1:0] minutes;
    logic [VAL_W-1:0] seconds;
  } time_val_t;

  function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] d);
    if (d > 4'd9) return SEG_DASH;
    return SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/bin2bcd_6b.sv
// Combinational 6-bit binary to tens/units split via compare/subtract ladder.
module bin2bcd_6b
  import seg7_pkg::*;
(
  input  logic [VAL_W-1:0] bin,
  output logic [2:0]       tens,
  output logic [3:0]       units,
  output logic             ovf
);

  always_comb begin
    ovf   = (bin > MAX_TIME_VAL);
    tens  = 3'd0;
    units = 4'(bin);
    if (bin >= 6'd50) begin
      tens  = 3'd5;
      units = 4'(bin - 6'd50);
    end else if (bin >= 6'd40) begin
      tens  = 3'd4;
      units = 4'(bin - 6'd40);
    end else if (bin >= 6'd30) begin
      tens  = 3'd3;
      units = 4'(bin - 6'd30);
    end else if (bin >= 6'd20) begin
      tens  = 3'd2;
      units = 4'(bin - 6'd20);
    end else if (bin >= 6'd10) begin
      tens  = 3'd1;
      units = 4'(bin - 6'd10);
    end
  end

endmodule

// File: rtl/seg7_time_display.sv
// 4-digit multiplexed MM.SS display driver with per-frame capture and blanking.
// Optional digit blinking enabled by defining SEG7_TIME_DISPLAY_BLINK_EN.
module seg7_time_display
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_en,
  input  logic [VAL_W-1:0] i_minutes,
  input  logic [VAL_W-1:0] i_seconds,
`ifdef SEG7_TIME_DISPLAY_BLINK_EN
  input  logic             blink_tick,
  input  logic [1:0]       blink_sel,
`endif
  output logic [3:0]       o_an,
  output logic [SEG_W-1:0] o_seg,
  output logic             o_dp,
  output logic             o_frame_done
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  digit_idx_t       idx_q, idx_nxt;
  scan_state_t      state_q, state_nxt;
  time_val_t        cap_q, src_c;
  logic             capture_c;

  logic [3:0]       an_nxt;
  logic [SEG_W-1:0] seg_nxt, digit_seg_c;
  logic             dp_nxt, fd_nxt;

  logic [2:0] min_tens_c, sec_tens_c;
  logic [3:0] min_units_c, sec_units_c;
  logic       min_ovf_c, sec_ovf_c;

`ifdef SEG7_TIME_DISPLAY_BLINK_EN
  logic phase_q, phase_nxt;
  assign phase_nxt = phase_q ^ (disp_en & blink_tick);
`endif

  // Frame start capture; forwarded so the first slot decodes the fresh value
  assign capture_c = disp_en && (cnt_q == '0) && (idx_q == 2'd0);

  always_comb begin
    src_c = cap_q;
    if (capture_c) begin
      src_c.minutes = i_minutes;
      src_c.seconds = i_seconds;
    end
  end

  bin2bcd_6b u_min_bcd (
    .bin   (src_c.minutes),
    .tens  (min_tens_c),
    .units (min_units_c),
    .ovf   (min_ovf_c)
  );

  bin2bcd_6b u_sec_bcd (
    .bin   (src_c.seconds),
    .tens  (sec_tens_c),
    .units (sec_units_c),
    .ovf   (sec_ovf_c)
  );

  // Slot counter and digit index
  always_comb begin
    cnt_nxt = cnt_q;
    idx_nxt = idx_q;
    if (!disp_en) begin
      cnt_nxt = '0;
      idx_nxt = 2'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = idx_q + 2'd1;
    end else begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  // Segment pattern for the digit about to be shown
  always_comb begin
    digit_seg_c = SEG_OFF;
    case (idx_nxt)
      2'd0:    digit_seg_c = sec_ovf_c ? SEG_DASH : seg_encode(sec_units_c);
      2'd1:    digit_seg_c = sec_ovf_c ? SEG_DASH : seg_encode({1'b0, sec_tens_c});
      2'd2:    digit_seg_c = min_ovf_c ? SEG_DASH : seg_encode(min_units_c);
      default: digit_seg_c = min_ovf_c ? SEG_DASH : seg_encode({1'b0, min_tens_c});
    endcase
`ifdef SEG7_TIME_DISPLAY_BLINK_EN
    if (phase_q && blink_sel[idx_nxt[1]]) digit_seg_c = SEG_OFF;
`endif
  end

  // Scan FSM next state and registered-output precompute
  always_comb begin
    state_nxt = ST_BLANK;
    an_nxt    = 4'hF;
    seg_nxt   = SEG_OFF;
    dp_nxt    = 1'b1;
    fd_nxt    = 1'b0;
    if (disp_en) begin
      case (state_q)
        ST_BLANK: state_nxt = (cnt_nxt >= CNT_BLANK) ? ST_DRIVE : ST_BLANK;
        ST_DRIVE: state_nxt = (cnt_nxt == '0) ? ST_BLANK : ST_DRIVE;
        default:  state_nxt = ST_BLANK;
      endcase
      fd_nxt = (cnt_nxt == CNT_LAST) && (idx_nxt == 2'd3);
      if (state_nxt == ST_DRIVE) begin
        an_nxt  = ~(4'b0001 << idx_nxt);
        seg_nxt = digit_seg_c;
        dp_nxt  = (idx_nxt != 2'd2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      state_q      <= ST_BLANK;
      cap_q        <= '0;
      o_an         <= 4'hF;
      o_seg        <= SEG_OFF;
      o_dp         <= 1'b1;
      o_frame_done <= 1'b0;
`ifdef SEG7_TIME_DISPLAY_BLINK_EN
      phase_q      <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_nxt;
      idx_q        <= idx_nxt;
      state_q      <= state_nxt;
      cap_q        <= src_c;
      o_an         <= an_nxt;
      o_seg        <= seg_nxt;
      o_dp         <= dp_nxt;
      o_frame_done <= fd_nxt;
`ifdef SEG7_TIME_DISPLAY_BLINK_EN
      phase_q      <= phase_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_seg7_time_display.sv
// Directed bench for seg7_time_display with SCAN_DIV=8, BLANK_CYC=2.
module tb_seg7_time_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000, DSH = 7'b0111111, OFF = 7'h7F;

  typedef logic [3:0][6:0] segs_t;
  typedef struct {
    logic [5:0] min;
    logic [5:0] sec;
    segs_t      segs;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       disp_en;
  logic [5:0] i_minutes, i_seconds;
  logic [3:0] o_an;
  logic [6:0] o_seg;
  logic       o_dp, o_frame_done;
`ifdef SEG7_TIME_DISPLAY_BLINK_EN
  logic       blink_tick;
  logic [1:0] blink_sel;
`endif

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  seg7_time_display #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .disp_en      (disp_en),
    .i_minutes    (i_minutes),
    .i_seconds    (i_seconds),
`ifdef SEG7_TIME_DISPLAY_BLINK_EN
    .blink_tick   (blink_tick),
    .blink_sel    (blink_sel),
`endif
    .o_an         (o_an),
    .o_seg        (o_seg),
    .o_dp         (o_dp),
    .o_frame_done (o_frame_done)
  );

  function automatic segs_t mk(input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0);
    segs_t r;
    r = {s3, s2, s1, s0};
    return r;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, k, act, exp);
    end
  endtask

  // Expected outputs at frame cycle k (k counts from the first enabled cycle)
  task automatic check_cycle(input int k, input segs_t segs);
    int kk = k % 32;
    int slot = kk % 8;
    int d = kk / 8;
    logic [3:0] one = 4'b0001;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edp;
    if (slot < 2) begin
      ean = 4'hF; eseg = OFF; edp = 1'b1;
    end else begin
      ean = ~(one << d); eseg = segs[d]; edp = (d == 2) ? 1'b0 : 1'b1;
    end
    chk("an", k, 32'(o_an), 32'(ean));
    chk("seg", k, 32'(o_seg), 32'(eseg));
    chk("dp", k, 32'(o_dp), 32'(edp));
    chk("frame_done", k, 32'(o_frame_done), (kk == 31) ? 32'd1 : 32'd0);
  endtask

  task automatic run(input segs_t segs, input int k_from, input int k_to);
    for (int k = k_from; k <= k_to; k++) begin
      @(negedge clk);
      check_cycle(k, segs);
    end
  endtask

  // Leaves the bench in frame cycle 0 with new inputs applied
  task automatic restart(input logic [5:0] m, input logic [5:0] s);
    @(negedge clk);
    disp_en = 1'b0;
    @(negedge clk);
    i_minutes = m;
    i_seconds = s;
    disp_en = 1'b1;
  endtask

  initial begin
    rst = 1'b0; disp_en = 1'b0; i_minutes = '0; i_seconds = '0;
`ifdef SEG7_TIME_DISPLAY_BLINK_EN
    blink_tick = 1'b0; blink_sel = 2'b00;
`endif
    vecs[0] = '{6'd12, 6'd34, mk(S1, S2, S3, S4)};
    vecs[1] = '{6'd60, 6'd59, mk(DSH, DSH, S5, S9)};
    vecs[2] = '{6'd0,  6'd0,  mk(S0, S0, S0, S0)};
    vecs[3] = '{6'd59, 6'd7,  mk(S5, S9, S0, S7)};
    vecs[4] = '{6'd63, 6'd60, mk(DSH, DSH, DSH, DSH)};
    vecs[5] = '{6'd48, 6'd16, mk(S4, S8, S1, S6)};
    vecs[6] = '{6'd9,  6'd50, mk(S0, S9, S5, S0)};
    vecs[7] = '{6'd10, 6'd9,  mk(S1, S0, S0, S9)};

    #12;
    chk("rst_an", 0, 32'(o_an), 32'hF);
    chk("rst_seg", 0, 32'(o_seg), 32'h7F);
    chk("rst_dp", 0, 32'(o_dp), 32'd1);
    chk("rst_fd", 0, 32'(o_frame_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      restart(vecs[i].min, vecs[i].sec);
      run(vecs[i].segs, 1, 32);
    end

    // Mid-frame input changes are held off until the next frame start
    restart(6'd12, 6'd34);
    run(mk(S1, S2, S3, S4), 1, 20);
    i_seconds = 6'd35;
    run(mk(S1, S2, S3, S4), 21, 32);
    run(mk(S1, S2, S3, S5), 33, 33);
    i_minutes = 6'd13;
    run(mk(S1, S2, S3, S5), 34, 64);
    run(mk(S1, S3, S3, S5), 65, 95);

    // disp_en dropped mid idx1 for 3 cycles, then a clean restart
    restart(6'd12, 6'd34);
    run(mk(S1, S2, S3, S4), 1, 10);
    disp_en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("en_low_an", j, 32'(o_an), 32'hF);
      chk("en_low_seg", j, 32'(o_seg), 32'h7F);
      chk("en_low_dp", j, 32'(o_dp), 32'd1);
      chk("en_low_fd", j, 32'(o_frame_done), 32'd0);
    end
    i_minutes = 6'd59;
    i_seconds = 6'd7;
    disp_en = 1'b1;
    run(mk(S5, S9, S0, S7), 1, 32);

    // Asynchronous reset during a DRIVE cycle
    restart(6'd12, 6'd34);
    run(mk(S1, S2, S3, S4), 1, 4);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_an", 4, 32'(o_an), 32'hF);
    chk("async_rst_seg", 4, 32'(o_seg), 32'h7F);
    chk("async_rst_dp", 4, 32'(o_dp), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    restart(6'd48, 6'd16);
    run(mk(S4, S8, S1, S6), 1, 32);

`ifdef SEG7_TIME_DISPLAY_BLINK_EN
    blink_sel = 2'b01;
    restart(6'd12, 6'd34);
    blink_tick = 1'b1;
    run(mk(S1, S2, OFF, OFF), 1, 1);
    blink_tick = 1'b0;
    run(mk(S1, S2, OFF, OFF), 2, 32);
    blink_tick = 1'b1;
    run(mk(S1, S2, S3, S4), 33, 33);
    blink_tick = 1'b0;
    run(mk(S1, S2, S3, S4), 34, 63);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_time_display.md
Name: seg7_time_display

Overview:
- Downstream display stage for the stopwatch/clock datapath.
- Consumes the 6-bit binary minutes/seconds pair and drives a 4-digit, common-anode, time-multiplexed 7-segment display (MM.SS).
- Captures inputs once per frame (tear-free), converts binary to BCD, and scans digits with anti-ghosting blanking.
- Emits a frame-done pulse for sequencing.

Parameters:
- SCAN_DIV, 1000: clk cycles per digit slot; must be > BLANK_CYC and >= 2.
- BLANK_CYC, 4: cycles at the start of each slot with all anodes off (ghost suppression); must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- disp_en  in  1  display enable; low = display dark and scan held
- i_minutes  in  6  binary minutes, valid 0..59
- i_seconds  in  6  binary seconds, valid 0..59
- o_an  out  4  active-low anode enables; bit0 = seconds units … bit3 = minutes tens
- o_seg  out  7  active-low segments, bit order {g,f,e,d,c,b,a}
- o_dp  out  1  active-low decimal point (minutes/seconds separator)
- o_frame_done  out  1  one-cycle pulse on the last cycle of the digit-3 slot

Behaviour:
- Reset is asynchronous, active-low, on rst; clock is clk. Reset values:
  - o_an = 4'hF, o_seg = 7'h7F, o_dp = 1, o_frame_done = 0
  - slot counter 0, digit index 0, FSM in BLANK, capture registers 0
- Slot counter:
  - Counts 0..SCAN_DIV-1 and wraps; digit index increments 0→1→2→3→0 on wrap.
- FSM, two states:
  - BLANK: slot counter < BLANK_CYC. o_an = 4'hF, o_seg = 7'h7F, o_dp = 1.
  - DRIVE: remaining cycles of the slot. o_an has exactly one bit low (the current digit index), and o_seg/o_dp show that digit.
  - All outputs are registered. The decoded values for a slot appear in the first DRIVE cycle.
- Capture:
  - At slot counter 0 of digit 0 (frame start), i_minutes and i_seconds are registered.
  - An input change mid-frame is not shown until the next frame start. Worst-case latency is 4*SCAN_DIV + 1 cycles.
- Conversion:
  - tens = v/10, units = v%10, using a compare/subtract ladder (no divider).
  - Captured value > 59 shows dash (7'b0111111, segment g only) on both digits of that pair.
- Digit map:
  - idx0 = seconds units, idx1 = seconds tens, idx2 = minutes units, idx3 = minutes tens.
  - No leading-zero suppression.
- o_dp is low only while DRIVE on idx2.
- o_frame_done is high for exactly one cycle: slot counter = SCAN_DIV-1 with idx = 3.
- disp_en:
  - Low: outputs go to reset values on the next clk edge; counters and FSM are held at reset state.
  - Rising: scan restarts at idx0 BLANK with a fresh capture on that cycle; no partial frame is output.
- Reset asserted mid-frame: immediate return to reset values.

Optional Feature:
- Macro: SEG7_TIME_DISPLAY_BLINK_EN.
- With the macro defined:
  - Extra inputs: blink_tick (1, one-cycle pulse) and blink_sel (2; bit0 = seconds pair, bit1 = minutes pair).
  - An internal blink phase toggles on each blink_tick; reset value is 0.
  - While phase = 1, digits of a selected pair are forced blank (o_seg = 7'h7F, anode still driven, o_dp unaffected).
  - blink_tick coincident with disp_en low: ignored; phase is held.
- Without the macro: ports are absent and there is no blanking.

Decomposition:
- Shared package seg7_pkg:
  - segment encodings SEG_DIGIT[0..9], SEG_DASH, SEG_OFF
  - digit index typedef (2-bit)
  - MAX_TIME_VAL = 59
- One sub-module: bin2bcd_6b (combinational, 6-bit in → tens[2:0], units[3:0], ovf flag). Instantiated twice.

Test Plan (SCAN_DIV=8, BLANK_CYC=2):
- Reset, then disp_en=1, i_minutes=12, i_seconds=34:
  - each slot gives 2 blank cycles then 6 drive cycles
  - idx0 o_seg=7'b0011001 (4), idx1 7'b0110000 (3), idx2 7'b0100100 (2) with o_dp=0, idx3 7'b1111001 (1)
  - o_frame_done pulses at cycle 31 of the frame
- Change i_seconds 34→35 during idx2: displayed digits unchanged until next frame start; idx0 then shows 5 (7'b0010010).
- i_minutes=60, i_seconds=59: idx2 and idx3 show 7'b0111111; seconds show 5 and 9.
- Drop disp_en for 3 cycles mid-idx1, then raise:
  - o_an=4'hF while low
  - restart at idx0 BLANK with new capture
  - no o_frame_done until 32 cycles later
- Assert rst mid-DRIVE: o_an=4'hF and o_seg=7'h7F immediately without a clock edge.
- With SEG7_TIME_DISPLAY_BLINK_EN, blink_sel=2'b01, one blink_tick: seconds digits show 7'h7F with anode low, minutes unaffected; second tick restores.
